// File: rtl/reset_controller_pkg.sv
// ResetControllerTypes: shared types and constants for the reset controller.
// It holds the sequencer state encoding, the bit positions within resetCause,
// and a small max helper used to size the shared timer.
package ResetControllerTypes;

  // Sequencer states:
  //   Hold    - all domains are held in reset
  //   Release - domains are being let go one by one
  //   Idle    - every domain is out of reset
  typedef enum logic [1:0] {
    Hold    = 2'd0,
    Release = 2'd1,
    Idle    = 2'd2
  } state_e;

  // Bit positions within resetCause.
  localparam int CausePor   = 3;
  localparam int CauseExt   = 2;
  localparam int CauseWdt   = 1;
  localparam int CauseSoft  = 0;
  localparam int CauseWidth = 4;

  // Cause value reported after a power-on reset.
  localparam logic [CauseWidth-1:0] CausePorOnly = 4'b1000;

  // Larger of two integers, for sizing the timer at elaboration.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_controller_timer.sv
// ResetTimer: a loadable down-counter that stops at zero.
// It is shared by the hold phase and the stagger gaps of the reset sequencer.
module ResetTimer #(
  parameter int               Width    = 4,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  output logic             o_zero
);

  logic [Width-1:0] r_count;

  // A load takes priority. Otherwise the count steps down and then stays at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= ResetVal;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/reset_controller.sv
// reset_controller: a staggered multi-domain reset sequencer.
// Domains are held in reset for HoldCycle edges, then released in ascending
// index order with StaggerCycle edges between them.
// Optional macro RESET_CONTROLLER_ACK_EN: when it is defined, domain i+1 is
// released only once domainReady[i] is seen high.
module reset_controller
  import ResetControllerTypes::*;
#(
  parameter int NumDomain    = 3,
  parameter int HoldCycle    = 16,
  parameter int StaggerCycle = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  extRstReq,
  input  logic                  wdtRstReq,
  input  logic                  softRstReq,
  input  logic [NumDomain-1:0]  domainReady,
  output logic [NumDomain-1:0]  rstOut,
  output logic                  busy,
  output logic [CauseWidth-1:0] resetCause
);

  localparam int CntW = $clog2(max_int(HoldCycle, StaggerCycle) + 1);
  localparam int IdxW = (NumDomain > 1) ? $clog2(NumDomain) : 1;

  // The timer is loaded with N-1. It passes zero on the Nth edge after the
  // load, and that edge performs the release.
  localparam logic [CntW-1:0] HoldLoad    = CntW'(HoldCycle - 1);
  localparam logic [CntW-1:0] StaggerLoad = CntW'(StaggerCycle - 1);
  localparam logic [IdxW-1:0] LastIdx     = IdxW'(NumDomain - 1);

  state_e                r_state;
  state_e                w_state_next;
  logic [NumDomain-1:0]  r_rst_out;
  logic [NumDomain-1:0]  w_rst_out_next;
  logic [CauseWidth-1:0] r_cause;
  logic [CauseWidth-1:0] w_cause_next;
  logic [IdxW-1:0]       r_idx;        // index of the most recently released domain
  logic [IdxW-1:0]       w_idx_next;
  logic [IdxW-1:0]       w_idx_inc;
  logic [CauseWidth-1:0] w_req_bits;
  logic                  w_req_any;
  logic                  w_load;
  logic [CntW-1:0]       w_load_val;
  logic                  w_zero;
  logic                  w_ack_ok;

  ResetTimer #(
    .Width    (CntW),
    .ResetVal (HoldLoad)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

`ifdef RESET_CONTROLLER_ACK_EN
  // The next domain may leave reset only after the previous one reports ready.
  assign w_ack_ok = domainReady[r_idx];
`else
  // Releases are purely timed, so the ready inputs have no effect.
  logic w_unused_ready;
  assign w_unused_ready = ^domainReady;
  assign w_ack_ok       = 1'b1;
`endif

  // Gather the request inputs into cause-bit positions.
  always_comb begin
    w_req_bits            = '0;
    w_req_bits[CauseExt]  = extRstReq;
    w_req_bits[CauseWdt]  = wdtRstReq;
    w_req_bits[CauseSoft] = softRstReq;
  end

  assign w_req_any = extRstReq | wdtRstReq | softRstReq;
  assign w_idx_inc = r_idx + 1'b1;

  // Next-state logic. Any request restarts the sequence from Hold. Otherwise
  // the timer's zero flag advances Hold -> Release -> Idle.
  always_comb begin
    w_state_next   = r_state;
    w_rst_out_next = r_rst_out;
    w_cause_next   = r_cause;
    w_idx_next     = r_idx;
    w_load         = 1'b0;
    w_load_val     = HoldLoad;

    if (w_req_any) begin
      w_state_next   = Hold;
      w_rst_out_next = '1;
      w_idx_next     = '0;
      w_load         = 1'b1;
      w_load_val     = HoldLoad;
      // A fresh sequence reports only the new cause. A restart keeps the
      // earlier causes, so no reason is lost.
      w_cause_next   = (r_state == Idle) ? w_req_bits : (r_cause | w_req_bits);
    end else begin
      unique case (r_state)
        Hold: begin
          if (w_zero) begin
            w_rst_out_next[0] = 1'b0;
            w_idx_next        = '0;
            if (NumDomain == 1) begin
              w_state_next = Idle;
            end else begin
              w_state_next = Release;
              w_load       = 1'b1;
              w_load_val   = StaggerLoad;
            end
          end
        end
        Release: begin
          if (w_zero && w_ack_ok) begin
            w_rst_out_next[w_idx_inc] = 1'b0;
            w_idx_next                = w_idx_inc;
            if (w_idx_inc == LastIdx) begin
              w_state_next = Idle;
            end else begin
              w_load     = 1'b1;
              w_load_val = StaggerLoad;
            end
          end
        end
        Idle: begin
          w_rst_out_next = '0;
        end
        default: begin
          w_state_next   = Hold;
          w_rst_out_next = '1;
          w_load         = 1'b1;
          w_load_val     = HoldLoad;
        end
      endcase
    end
  end

  // State and output registers. rst forces a full power-on reset at once,
  // without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= Hold;
      r_rst_out <= '1;
      r_cause   <= CausePorOnly;
      r_idx     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rst_out <= w_rst_out_next;
      r_cause   <= w_cause_next;
      r_idx     <= w_idx_next;
    end
  end

  assign rstOut     = r_rst_out;
  assign busy       = |r_rst_out;
  assign resetCause = r_cause;

endmodule

// File: tb/tb_reset_controller.sv
// tb_reset_controller: scoreboard bench for reset_controller.
// It uses NumDomain=3, HoldCycle=4 and StaggerCycle=2.
// The stimulus pushes hand-computed expected outputs into queues. A separate
// monitor pops each entry and compares it with the DUT outputs.
module tb_reset_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       extRstReq;
  logic       wdtRstReq;
  logic       softRstReq;
  logic [2:0] domainReady;
  logic [2:0] rstOut;
  logic       busy;
  logic [3:0] resetCause;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_rst_q[$];
  logic [3:0] exp_cause_q[$];
  string      name_q[$];
  event       async_ev;

  reset_controller #(
    .NumDomain    (3),
    .HoldCycle    (4),
    .StaggerCycle (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .extRstReq   (extRstReq),
    .wdtRstReq   (wdtRstReq),
    .softRstReq  (softRstReq),
    .domainReady (domainReady),
    .rstOut      (rstOut),
    .busy        (busy),
    .resetCause  (resetCause)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach its end, required completion");
    $fatal(1);
  end

  // Monitor: compare every queued expectation with the DUT outputs.
  initial begin
    logic [2:0] er;
    logic [3:0] ec;
    string      nm;
    forever begin
      @(negedge clk or async_ev);
      while (exp_rst_q.size() > 0) begin
        er = exp_rst_q.pop_front();
        ec = exp_cause_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (rstOut !== er || busy !== (|er) || resetCause !== ec) begin
          errors++;
          $display("FAIL %s: got rstOut=%b busy=%b cause=%b, required rstOut=%b busy=%b cause=%b",
                   nm, rstOut, busy, resetCause, er, |er, ec);
        end else begin
          $display("ok   %s: rstOut=%b busy=%b cause=%b", nm, rstOut, busy, resetCause);
        end
      end
    end
  end

  // Drive the request bits {ext,wdt,soft} for one edge, then queue the
  // outputs expected after that edge.
  task automatic step(input logic [2:0] req, input logic [2:0] er,
                      input logic [3:0] ec, input string nm);
    {extRstReq, wdtRstReq, softRstReq} = req;
    @(posedge clk);
    #1;
    {extRstReq, wdtRstReq, softRstReq} = 3'b000;
    exp_rst_q.push_back(er);
    exp_cause_q.push_back(ec);
    name_q.push_back(nm);
  endtask

  task automatic steps(input int n, input logic [2:0] req, input logic [2:0] er,
                       input logic [3:0] ec, input string nm);
    for (int i = 0; i < n; i++) step(req, er, ec, $sformatf("%s[%0d]", nm, i));
  endtask

  // Timing after rst is released, or after a request edge t: the outputs
  // change on edges t+4, t+6 and t+8.
  task automatic tail_from_t1(input logic [3:0] ec, input string nm);
    steps(3, 3'b000, 3'b111, ec, {nm, " held"});
    steps(2, 3'b000, 3'b110, ec, {nm, " d0 out"});
    steps(2, 3'b000, 3'b100, ec, {nm, " d1 out"});
    step(3'b000, 3'b000, ec, {nm, " all out"});
  endtask

  initial begin
    rst = 1'b1;
    {extRstReq, wdtRstReq, softRstReq} = 3'b000;
`ifdef RESET_CONTROLLER_ACK_EN
    domainReady = 3'b111;
`else
    domainReady = 3'b000;   // timed releases must not depend on ready
`endif

    // Power-on: outputs are forced while rst is high.
    steps(2, 3'b000, 3'b111, 4'b1000, "in reset");
    rst = 1'b0;                              // released before edge 1
    tail_from_t1(4'b1000, "por");            // edges 1..8
    steps(11, 3'b000, 3'b000, 4'b1000, "idle");  // edges 9..19

    // Software request from Idle: the cause is replaced.
    step(3'b001, 3'b111, 4'b0001, "soft e20");
    steps(3, 3'b000, 3'b111, 4'b0001, "soft hold");
    step(3'b000, 3'b110, 4'b0001, "soft e24 d0 out");

    // Watchdog request mid-Release: the sequence restarts and the cause accumulates.
    step(3'b010, 3'b111, 4'b0011, "wdt e25 restart");
    tail_from_t1(4'b0011, "wdt");            // d0 out after e29
    steps(2, 3'b000, 3'b000, 4'b0011, "idle2");

    // Simultaneous ext and wdt requests from Idle.
    step(3'b110, 3'b111, 4'b0110, "ext+wdt");
    tail_from_t1(4'b0110, "ext+wdt");

    // A request held high keeps the controller in Hold.
    steps(6, 3'b001, 3'b111, 4'b0001, "soft held");
    steps(3, 3'b000, 3'b111, 4'b0001, "after held");
    step(3'b000, 3'b110, 4'b0001, "after held d0 out");

    // Assert rst mid-Release, away from any clock edge.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_rst_q.push_back(3'b111);
    exp_cause_q.push_back(4'b1000);
    name_q.push_back("async rst");
    ->async_ev;
    steps(2, 3'b000, 3'b111, 4'b1000, "rst held");
    rst = 1'b0;
    tail_from_t1(4'b1000, "por2");

`ifdef RESET_CONTROLLER_ACK_EN
    // A low ready on domain 0 stalls the release of domain 1.
    step(3'b001, 3'b111, 4'b0001, "ack soft");
    steps(3, 3'b000, 3'b111, 4'b0001, "ack hold");
    domainReady = 3'b110;
    step(3'b000, 3'b110, 4'b0001, "ack d0 out");
    steps(10, 3'b000, 3'b110, 4'b0001, "ack wait");
    domainReady = 3'b111;
    step(3'b000, 3'b100, 4'b0001, "ack d1 out");
    step(3'b000, 3'b100, 4'b0001, "ack gap");
    step(3'b000, 3'b000, 4'b0001, "ack all out");
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_rst_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left in queue, required 0", exp_rst_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
